// File: rtl/wb_spi_sram_multi_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : wb_spi_sram_multi_if                                          |
// | Purpose   : Wishbone-classic byte bus between a WB master and the         |
// |             multi-device SPI SRAM controller.                             |
// | Revision  : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Signals (named from the slave's point of view)                            |
// |   cyc_i  1          bus cycle                                             |
// |   stb_i  1          strobe                                                |
// |   adr_i  ADR_WIDTH  {chip-select index, byte address}                     |
// |   dat_i  8          write data                                            |
// |   we_i   1          1 = write, 0 = read                                   |
// |   ack_o  1          one-cycle completion pulse                            |
// |   err_o  1          one-cycle error pulse                                 |
// |   rty_o  1          retry, never asserted                                 |
// |   dat_o  8          read data, valid while ack_o is high                  |
// | Modports: master (drives requests), slave (drives responses)             |
// +--------------------------------------------------------------------------+
interface wb_spi_sram_multi_if #(
  parameter int ADR_WIDTH = 24
);
  logic                 cyc_i;
  logic                 stb_i;
  logic [ADR_WIDTH-1:0] adr_i;
  logic [7:0]           dat_i;
  logic                 we_i;
  logic                 ack_o;
  logic                 err_o;
  logic                 rty_o;
  logic [7:0]           dat_o;

  modport master (
    output cyc_i, stb_i, adr_i, dat_i, we_i,
    input  ack_o, err_o, rty_o, dat_o
  );

  modport slave (
    input  cyc_i, stb_i, adr_i, dat_i, we_i,
    output ack_o, err_o, rty_o, dat_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_spi_sram_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : wb_spi_sram_multi                                             |
// | Purpose   : Wishbone-classic slave driving up to NUM_CS serial SPI SRAMs  |
// |             (23LC1024-class) on a shared SCK/MOSI/MISO bus. Each access   |
// |             is a 40-bit mode-0 frame: command, 24-bit address, data byte. |
// |             Upper address bits select the device; an index beyond the    |
// |             fitted devices answers with err_o. Dropping cyc_i mid-frame   |
// |             aborts the access without ack_o.                              |
// | Optional  : define SPI_SEQ_EN to keep the device selected after an access |
// |             and stream the next consecutive byte with only 8 data bits.   |
// | Revision  : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Ports                                                                     |
// |   clk_i   in   1       system clock                                       |
// |   rst_i   in   1       synchronous active-high reset                      |
// |   wb      slave        Wishbone bus (cyc/stb/adr/dat/we, ack/err/rty/dat) |
// |   sck     out  1       SPI clock, idles low                               |
// |   mosi    out  1       SPI data out, MSB first                            |
// |   miso    in   1       SPI data in, sampled as sck rises                  |
// |   ss_n    out  NUM_CS  active-low selects, at most one low               |
// +--------------------------------------------------------------------------+
module wb_spi_sram_multi #(
  parameter int MEM_ADDR_WIDTH = 23,
  parameter int CS_WIDTH       = 1,
  parameter int NUM_CS         = 2,
  parameter int SCK_DIV        = 1
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  wb_spi_sram_multi_if.slave wb,
  output logic               sck,
  output logic               mosi,
  input  wire logic          miso,
  output logic [NUM_CS-1:0]  ss_n
);

  localparam int              DIV_W     = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [5:0]      LAST_BIT  = 6'd39;
  localparam logic [7:0]      CMD_READ  = 8'h03;
  localparam logic [7:0]      CMD_WRITE = 8'h02;
`ifdef SPI_SEQ_EN
  // A streamed access only sends the final 8 bits of the frame.
  localparam logic [5:0]      SEQ_FIRST_BIT = 6'd32;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_DONE  = 3'd2,
    S_GAP   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t                    r_state;
  logic [DIV_W-1:0]          r_div;   // half-period counter, reused as GAP timer
  logic [5:0]                r_bit;   // index of the bit currently on mosi
  logic [39:0]               r_tx;    // bits still to send, next one at [39]
  logic [7:0]                r_rx;    // last 8 bits sampled from miso
  logic                      r_we;
`ifdef SPI_SEQ_EN
  logic [CS_WIDTH-1:0]       r_cs;
  logic [MEM_ADDR_WIDTH-1:0] r_adr;
`endif

  logic [CS_WIDTH-1:0]       w_req_cs;
  logic [MEM_ADDR_WIDTH-1:0] w_req_adr;
  logic                      w_req;
  logic                      w_cs_bad;
  logic [7:0]                w_cmd;
  logic [7:0]                w_wdata;
  logic [39:0]               w_frame;
  logic [NUM_CS-1:0]         w_sel_n;

  assign w_req_cs  = wb.adr_i[MEM_ADDR_WIDTH +: CS_WIDTH];
  assign w_req_adr = wb.adr_i[MEM_ADDR_WIDTH-1:0];

  // A request still asserted in the cycle its ack/err is showing belongs to
  // the finished access, so it must not be taken as a new one.
  assign w_req    = wb.cyc_i & wb.stb_i & ~wb.ack_o & ~wb.err_o;
  assign w_cs_bad = (int'(w_req_cs) >= NUM_CS);

  assign w_cmd   = wb.we_i ? CMD_WRITE : CMD_READ;
  assign w_wdata = wb.we_i ? wb.dat_i : 8'h00;   // mosi stays low for read data
  assign w_frame = {w_cmd, 24'(w_req_adr), w_wdata};

  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_sel
    assign w_sel_n[gi] = (w_req_cs != CS_WIDTH'(gi));
  end

`ifdef SPI_SEQ_EN
  logic w_seq_hit;
  // The next byte of a stream: same device, same direction, address +1 with
  // no wrap past the top of the device.
  assign w_seq_hit = (w_req_cs == r_cs) && (wb.we_i == r_we) &&
                     (r_adr != '1) && (w_req_adr == r_adr + 1'b1);
`endif

  assign wb.rty_o = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bit    <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_we     <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= '1;
      wb.ack_o <= 1'b0;
      wb.err_o <= 1'b0;
      wb.dat_o <= '0;
`ifdef SPI_SEQ_EN
      r_cs     <= '0;
      r_adr    <= '0;
`endif
    end else begin
      wb.ack_o <= 1'b0;
      wb.err_o <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_cs_bad) begin
              wb.err_o <= 1'b1;
            end else begin
              r_we    <= wb.we_i;
`ifdef SPI_SEQ_EN
              r_cs    <= w_req_cs;
              r_adr   <= w_req_adr;
`endif
              // First bit goes out with the select; the rest wait in r_tx.
              mosi    <= w_frame[39];
              r_tx    <= {w_frame[38:0], 1'b0};
              r_bit   <= '0;
              r_div   <= '0;
              sck     <= 1'b0;
              ss_n    <= w_sel_n;
              r_state <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          if (!wb.cyc_i) begin
            // Abort: release the device immediately, no response.
            ss_n    <= '1;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            r_div   <= '0;
            r_state <= S_GAP;
          end else if (r_div != DIV_LAST) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!sck) begin
              sck  <= 1'b1;
              r_rx <= {r_rx[6:0], miso};
            end else begin
              // Falling edge: the only place mosi is allowed to move.
              sck <= 1'b0;
              if (r_bit == LAST_BIT) begin
                mosi    <= 1'b0;
                r_state <= S_DONE;
              end else begin
                mosi  <= r_tx[39];
                r_tx  <= {r_tx[38:0], 1'b0};
                r_bit <= r_bit + 1'b1;
              end
            end
          end
        end

        S_DONE: begin
          wb.ack_o <= 1'b1;
          if (!r_we) begin
            wb.dat_o <= r_rx;
          end
`ifdef SPI_SEQ_EN
          if (wb.cyc_i) begin
            r_state <= S_HOLD;
          end else begin
            ss_n    <= '1;
            r_div   <= '0;
            r_state <= S_GAP;
          end
`else
          ss_n    <= '1;
          r_div   <= '0;
          r_state <= S_GAP;
`endif
        end

        S_GAP: begin
          // SCK_DIV cycles here plus the IDLE cycle that samples the next
          // request keep the selects high for SCK_DIV+1 cycles.
          if (r_div != DIV_LAST) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div   <= '0;
            r_state <= S_IDLE;
          end
        end

`ifdef SPI_SEQ_EN
        S_HOLD: begin
          if (!wb.cyc_i) begin
            ss_n    <= '1;
            r_div   <= '0;
            r_state <= S_GAP;
          end else if (w_req) begin
            if (w_seq_hit) begin
              // Device auto-increments: only the data byte is exchanged.
              r_adr   <= w_req_adr;
              mosi    <= w_wdata[7];
              r_tx    <= {w_wdata[6:0], 33'b0};
              r_bit   <= SEQ_FIRST_BIT;
              r_div   <= '0;
              sck     <= 1'b0;
              r_state <= S_SHIFT;
            end else begin
              // Not a continuation: close the stream; the request is still
              // held by the master and is served as a full frame from IDLE.
              ss_n    <= '1;
              r_div   <= '0;
              r_state <= S_GAP;
            end
          end
        end
`endif

        default: begin
          ss_n    <= '1;
          sck     <= 1'b0;
          mosi    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_spi_sram_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_wb_spi_sram_multi                                          |
// | Purpose   : Directed self-checking bench for wb_spi_sram_multi. Two      |
// |             instances: a 2-device default build and a 3-device build    |
// |             with a 2-bit select index. A small SPI SRAM model captures  |
// |             mosi and returns read bytes counting up from rd_base.       |
// | Revision  : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_wb_spi_sram_multi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_spi_sram_multi_if #(.ADR_WIDTH(24)) wb ();
  wb_spi_sram_multi_if #(.ADR_WIDTH(25)) wb3 ();

  logic       sck, mosi, miso;
  logic [1:0] ss_n;
  logic       sck3, mosi3, miso3;
  logic [2:0] ss_n3;
  assign miso3 = 1'b0;

  wb_spi_sram_multi #(
    .MEM_ADDR_WIDTH(23), .CS_WIDTH(1), .NUM_CS(2), .SCK_DIV(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wb(wb),
    .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  wb_spi_sram_multi #(
    .MEM_ADDR_WIDTH(23), .CS_WIDTH(2), .NUM_CS(3), .SCK_DIV(1)
  ) dut3 (
    .clk_i(clk), .rst_i(rst), .wb(wb3),
    .sck(sck3), .mosi(mosi3), .miso(miso3), .ss_n(ss_n3)
  );

`ifdef SPI_SEQ_EN
  localparam int         EXP_LAT2    = 18;
  localparam int         EXP_GAP     = 0;
  localparam logic [7:0] EXP_RD2     = 8'h12;
  localparam logic [1:0] EXP_SS_ACK  = 2'b10;
`else
  localparam int         EXP_LAT2    = 82;
  localparam int         EXP_GAP     = 2;
  localparam logic [7:0] EXP_RD2     = 8'h11;
  localparam logic [1:0] EXP_SS_ACK  = 2'b11;
`endif

  // ---------------- SPI SRAM model for dut ----------------
  logic        sck_d   = 1'b0;
  int unsigned spi_cnt = 0;
  logic [39:0] cap     = '0;
  logic [7:0]  rd_base = 8'h00;

  always @(posedge clk) begin
    sck_d <= sck;
    if (&ss_n) begin
      spi_cnt <= 0;
    end else if (sck && !sck_d) begin
      spi_cnt <= spi_cnt + 1;
      cap     <= {cap[38:0], mosi};
    end
  end

  function automatic logic model_bit(input int unsigned cnt, input logic [7:0] base);
    logic [7:0]  b;
    int unsigned rel;
    if (cnt < 32) return 1'b0;
    rel = cnt - 32;
    b   = base + 8'(rel >> 3);
    return b[7 - (rel & 7)];
  endfunction

  assign miso = model_bit(spi_cnt, rd_base);

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit which, input logic [24:0] adr, input logic we,
                       input logic [7:0] dat);
    if (!which) begin
      wb.adr_i = adr[23:0]; wb.we_i = we; wb.dat_i = dat;
      wb.cyc_i = 1'b1;      wb.stb_i = 1'b1;
    end else begin
      wb3.adr_i = adr; wb3.we_i = we; wb3.dat_i = dat;
      wb3.cyc_i = 1'b1; wb3.stb_i = 1'b1;
    end
  endtask

  task automatic release_bus();
    wb.cyc_i  = 1'b0; wb.stb_i  = 1'b0;
    wb3.cyc_i = 1'b0; wb3.stb_i = 1'b0;
  endtask

  // Returns in the ack cycle. lat = cycles after the request cycle (-1 on
  // timeout); matchc = non-ack cycles whose selects equal ss_exp.
  task automatic wait_ack(input bit which, input logic [2:0] ss_exp,
                          output int lat, output int matchc, output int errc);
    logic       a, e;
    logic [2:0] s;
    lat = -1; matchc = 0; errc = 0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      a = which ? wb3.ack_o : wb.ack_o;
      e = which ? wb3.err_o : wb.err_o;
      s = which ? ss_n3 : {1'b0, ss_n};
      if (e) errc++;
      if (a) begin
        lat = n;
        break;
      end
      if (s == ss_exp) matchc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, lowc, errc, gap, acks;

    rst = 1'b1;
    wb.cyc_i = 0;  wb.stb_i = 0;  wb.adr_i = '0;  wb.dat_i = '0;  wb.we_i = 0;
    wb3.cyc_i = 0; wb3.stb_i = 0; wb3.adr_i = '0; wb3.dat_i = '0; wb3.we_i = 0;
    repeat (3) tick();

    // ---- reset state ----
    check("rst_ss_n",  ss_n,      2'b11);
    check("rst_sck",   sck,       1'b0);
    check("rst_mosi",  mosi,      1'b0);
    check("rst_ack",   wb.ack_o,  1'b0);
    check("rst_err",   wb.err_o,  1'b0);
    check("rst_dat",   wb.dat_o,  8'h00);
    check("rst_rty",   wb.rty_o,  1'b0);
    check("rst_ss_n3", ss_n3,     3'b111);
    check("rst_rty3",  wb3.rty_o, 1'b0);
    rst = 1'b0;
    tick();

    // ---- read cs1, adr 0x800123, device returns 0x3C ----
    rd_base = 8'h3C;
    start(0, 25'h0800123, 1'b0, 8'h00);
    wait_ack(0, 3'b001, lat, lowc, errc);
    check("rd_latency",  lat,        82);
    check("rd_data",     wb.dat_o,   8'h3C);
    check("rd_ss_low",   lowc,       81);
    check("rd_mosi_hdr", cap[39:8],  32'h03000123);
    check("rd_mosi_dat", cap[7:0],   8'h00);
    check("rd_no_err",   errc,       0);
    release_bus();
    tick();
    check("rd_ack_pulse", wb.ack_o, 1'b0);
    check("rd_dat_hold",  wb.dat_o, 8'h3C);
    tick();

    // ---- write cs0, adr 0x000010, data 0xA5 ----
    start(0, 25'h0000010, 1'b1, 8'hA5);
    wait_ack(0, 3'b010, lat, lowc, errc);
    check("wr_latency",   lat,       82);
    check("wr_ss_low",    lowc,      81);
    check("wr_mosi",      cap,       40'h02000010A5);
    check("wr_dat_kept",  wb.dat_o,  8'h3C);
    check("wr_ss_ackcyc", ss_n,      EXP_SS_ACK);
    release_bus();
    tick();
    check("wr_ss_after",  ss_n,      2'b11);
    tick();

    // ---- out-of-range select on the 3-device build ----
    start(1, {2'b11, 23'h000005}, 1'b0, 8'h00);
    tick();
    check("err_pulse",   wb3.err_o, 1'b1);
    check("err_no_ack",  wb3.ack_o, 1'b0);
    check("err_ss_n",    ss_n3,     3'b111);
    check("err_sck",     sck3,      1'b0);
    release_bus();
    tick();
    check("err_one_cyc", wb3.err_o, 1'b0);
    check("err_ss_n2",   ss_n3,     3'b111);
    check("err_mosi",    mosi3,     1'b0);
    tick();

    // ---- highest valid select on the 3-device build ----
    start(1, {2'b10, 23'h000020}, 1'b1, 8'h66);
    wait_ack(1, 3'b011, lat, lowc, errc);
    check("cs2_latency", lat,  82);
    check("cs2_ss_low",  lowc, 81);
    check("cs2_no_err",  errc, 0);
    release_bus();
    repeat (2) tick();

    // ---- abort: drop cyc_i in cycle 20 of a read ----
    start(0, 25'h0000040, 1'b0, 8'h00);
    repeat (20) tick();
    check("abort_ss_active", ss_n, 2'b10);
    release_bus();
    tick();
    check("abort_ss_n", ss_n, 2'b11);
    check("abort_sck",  sck,  1'b0);
    acks = 0;
    for (int n = 0; n < 100; n++) begin
      if (wb.ack_o || wb.err_o) acks++;
      tick();
    end
    check("abort_no_resp", acks, 0);

    // ---- next request after abort completes normally ----
    start(0, 25'h0800077, 1'b1, 8'h5A);
    wait_ack(0, 3'b001, lat, lowc, errc);
    check("post_abort_lat",  lat,  82);
    check("post_abort_mosi", cap,  40'h020000775A);
    check("post_abort_ss",   lowc, 81);
    release_bus();
    repeat (2) tick();

    // ---- reset in cycle 40 of a write ----
    start(0, 25'h0000200, 1'b1, 8'hC3);
    repeat (40) tick();
    rst = 1'b1;
    tick();
    check("mrst_ss_n", ss_n,     2'b11);
    check("mrst_sck",  sck,      1'b0);
    check("mrst_mosi", mosi,     1'b0);
    check("mrst_ack",  wb.ack_o, 1'b0);
    check("mrst_dat",  wb.dat_o, 8'h00);
    rst = 1'b0;
    release_bus();
    acks = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (wb.ack_o) acks++;
    end
    check("mrst_no_ack", acks, 0);

    // ---- back-to-back reads 0x000100, 0x000101 under one cyc_i ----
    rd_base = 8'h11;
    start(0, 25'h0000100, 1'b0, 8'h00);
    wait_ack(0, 3'b010, lat, lowc, errc);
    check("b2b_lat1",  lat,      82);
    check("b2b_data1", wb.dat_o, 8'h11);
    gap = (ss_n == 2'b11) ? 1 : 0;
    tick();
    gap += (ss_n == 2'b11) ? 1 : 0;
    wb.adr_i = 24'h000101;
    wait_ack(0, 3'b011, lat, lowc, errc);
    gap += lowc;
    check("b2b_lat2",  lat,      EXP_LAT2);
    check("b2b_gap",   gap,      EXP_GAP);
    check("b2b_data2", wb.dat_o, EXP_RD2);
    release_bus();
    repeat (4) tick();
    check("b2b_idle_ss", ss_n, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
